// File: rtl/fir_ctrl_pkg.sv
// Shared state encoding and default widths for the FIR stream sequencer.
package fir_ctrl_pkg;

   localparam int DEF_X_N_SIZE     = 8;
   localparam int DEF_TAP_SIZE     = 3;
   localparam int DEF_NBR_OF_TAPS  = 4;
   localparam int DEF_SETUP_CYCLES = 4;

   typedef enum logic [2:0] {
      ST_SETUP  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_STREAM = 3'd2,
      ST_LOAD   = 3'd3,
      ST_REPLAY = 3'd4,
      ST_GAP    = 3'd5
   } fir_state_e;

   // Index width that never collapses to zero bits.
   function automatic int width_of(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/fir_coef_buf.sv
// Coefficient set storage: one write port, one combinational read port, synchronous clear.
module fir_coef_buf
   import fir_ctrl_pkg::*;
#(
   parameter int TAP_SIZE    = DEF_TAP_SIZE,
   parameter int NBR_OF_TAPS = DEF_NBR_OF_TAPS,
   parameter int IDX_W       = width_of(DEF_NBR_OF_TAPS)
) (
   input  logic                clk_i,
   input  logic                clr_i,
   input  logic                we_i,
   input  logic [IDX_W-1:0]    widx_i,
   input  logic [TAP_SIZE-1:0] wdata_i,
   input  logic [IDX_W-1:0]    ridx_i,
   output logic [TAP_SIZE-1:0] rdata_o
);

   logic [TAP_SIZE-1:0] mem_q [NBR_OF_TAPS];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < NBR_OF_TAPS; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequencer in front of the adaptive FIR: sample streaming, coefficient load and replay.
//  state  | meaning
//  SETUP  | FIR tap-init wait after reset
//  IDLE   | waiting for a config request or a sample
//  STREAM | forwarding samples, 2 empty cycles end the burst
//  LOAD   | capturing a coefficient set into the buffer
//  REPLAY | lead-in + N coefficients on x_n with set_coeffs
//  GAP    | one quiet cycle before IDLE
module fir_stream_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int X_N_SIZE     = DEF_X_N_SIZE,
   parameter int TAP_SIZE     = DEF_TAP_SIZE,
   parameter int NBR_OF_TAPS  = DEF_NBR_OF_TAPS,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [X_N_SIZE-1:0] s_sample_tdata,
   input  logic                s_sample_tvalid,
   output logic                s_sample_tready,
   input  logic [TAP_SIZE-1:0] s_cfg_tdata,
   input  logic                s_cfg_tvalid,
   input  logic                s_cfg_tlast,
   output logic                s_cfg_tready,
   output logic [X_N_SIZE-1:0] fir_x_n,
   output logic                fir_tvalid,
   output logic                fir_set_coeffs,
   output logic                y_valid,
   output logic                busy,
   output logic                cfg_err
);

   localparam int K_W   = $clog2(NBR_OF_TAPS + 1);
   localparam int SC_W  = width_of(SETUP_CYCLES);
   localparam int IDX_W = width_of(NBR_OF_TAPS);

   fir_state_e          state_q, state_d;
   logic [SC_W-1:0]     setup_cnt_q, setup_cnt_d;
   logic [K_W-1:0]      k_q, k_d;
   logic                miss_q, miss_d;
   logic [X_N_SIZE-1:0] x_n_q, x_n_d;
   logic                tvalid_q, tvalid_d;
   logic                set_q, set_d;
   logic                yv_q;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic                sample_acc, cfg_acc;
   logic                buf_clr, buf_we;
   logic [IDX_W-1:0]    rd_idx;
   logic [TAP_SIZE-1:0] rd_data;

   assign s_sample_tready = ((state_q == ST_IDLE) || (state_q == ST_STREAM)) && !s_cfg_tvalid;
   assign s_cfg_tready    = (state_q == ST_LOAD);
   assign sample_acc      = s_sample_tvalid && s_sample_tready;
   assign cfg_acc         = s_cfg_tvalid && s_cfg_tready;

   fir_coef_buf #(
      .TAP_SIZE    (TAP_SIZE),
      .NBR_OF_TAPS (NBR_OF_TAPS),
      .IDX_W       (IDX_W)
   ) u_buf (
      .clk_i   (clk),
      .clr_i   (buf_clr),
      .we_i    (buf_we),
      .widx_i  (k_q[IDX_W-1:0]),
      .wdata_i (s_cfg_tdata),
      .ridx_i  (rd_idx),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SETUP;
         setup_cnt_q <= '0;
         k_q         <= '0;
         miss_q      <= 1'b0;
         x_n_q       <= '0;
         tvalid_q    <= 1'b0;
         set_q       <= 1'b0;
         yv_q        <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         setup_cnt_q <= setup_cnt_d;
         k_q         <= k_d;
         miss_q      <= miss_d;
         x_n_q       <= x_n_d;
         tvalid_q    <= tvalid_d;
         set_q       <= set_d;
         yv_q        <= tvalid_q;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      setup_cnt_d = setup_cnt_q;
      k_d         = k_q;
      miss_d      = miss_q;
      buf_clr     = reset;
      buf_we      = 1'b0;
      case (state_q)
         ST_SETUP: begin
            if (setup_cnt_q == SC_W'(SETUP_CYCLES - 1)) state_d = ST_IDLE;
            else setup_cnt_d = setup_cnt_q + SC_W'(1);
         end
         ST_IDLE: begin
            if (s_cfg_tvalid) begin
               state_d = ST_LOAD;
               k_d     = '0;
               buf_clr = 1'b1;
            end else if (sample_acc) begin
               state_d = ST_STREAM;
               miss_d  = 1'b0;
            end
         end
         ST_STREAM: begin
            if (s_cfg_tvalid) begin
               state_d = ST_LOAD;
               k_d     = '0;
               buf_clr = 1'b1;
            end else if (sample_acc) begin
               miss_d = 1'b0;
            end else if (miss_q) begin
               state_d = ST_IDLE;
            end else begin
               miss_d = 1'b1;
            end
         end
         ST_LOAD: begin
            // k saturates at N so surplus words are swallowed without writing
            if (cfg_acc) begin
               if (k_q != K_W'(NBR_OF_TAPS)) begin
                  buf_we = 1'b1;
                  k_d    = k_q + K_W'(1);
               end
               if (s_cfg_tlast) begin
                  state_d = ST_REPLAY;
                  k_d     = '0;
               end
            end
         end
         ST_REPLAY: begin
            if (k_q == K_W'(NBR_OF_TAPS)) begin
               state_d = ST_GAP;
               k_d     = '0;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_SETUP;
      endcase
   end

   // Replay step j reads buf[N-j]; decoded against constants to keep the datapath increment-only.
   always_comb begin
      rd_idx = '0;
      for (int i = 0; i < NBR_OF_TAPS; i++) begin
         if (k_q == K_W'(NBR_OF_TAPS - i)) rd_idx = IDX_W'(i);
      end
   end

   always_comb begin
      x_n_d    = '0;
      tvalid_d = 1'b0;
      set_d    = 1'b0;
      busy_d   = (state_q != ST_IDLE);
      err_d    = 1'b0;
      if (sample_acc) begin
         x_n_d    = s_sample_tdata;
         tvalid_d = 1'b1;
      end
      if (state_q == ST_REPLAY) begin
         set_d = 1'b1;
         if (k_q != '0) x_n_d = X_N_SIZE'($signed(rd_data));
      end
      if (cfg_acc) begin
         if (s_cfg_tlast && (k_q < K_W'(NBR_OF_TAPS - 1))) err_d = 1'b1;
         if (!s_cfg_tlast && (k_q == K_W'(NBR_OF_TAPS - 1))) err_d = 1'b1;
      end
   end

   assign fir_x_n        = x_n_q;
   assign fir_tvalid     = tvalid_q;
   assign fir_set_coeffs = set_q;
   assign y_valid        = yv_q;
   assign busy           = busy_q;
   assign cfg_err        = err_q;

endmodule
